// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with count, status flags, error pulses and
// a selectable registered or first-word-fall-through read port.
module sync_fifo_flags #(
    parameter type dtype      = logic [7:0],
    parameter int  BUFF_SIZE  = 8,
    parameter bit  FWFT       = 1'b0,
    parameter int  AFULL_LVL  = BUFF_SIZE - 2,
    parameter int  AEMPTY_LVL = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  dtype                         data_in,
    output dtype                         data_out,
    output logic                         out_valid,
    output logic [$clog2(BUFF_SIZE+1)-1:0] count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = (BUFF_SIZE > 1) ? $clog2(BUFF_SIZE) : 1;
    localparam int CW = $clog2(BUFF_SIZE + 1);

    generate
        if (BUFF_SIZE < 2) begin : g_bad_size
            $error("sync_fifo_flags: BUFF_SIZE must be >= 2");
        end
        if (AFULL_LVL < 1 || AFULL_LVL > BUFF_SIZE) begin : g_bad_afull
            $error("sync_fifo_flags: AFULL_LVL out of range");
        end
        if (AEMPTY_LVL < 0 || AEMPTY_LVL > BUFF_SIZE - 1) begin : g_bad_aempty
            $error("sync_fifo_flags: AEMPTY_LVL out of range");
        end
    endgenerate

    dtype          mem [BUFF_SIZE];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] cnt;
    logic          pop_ok;
    logic          push_ok;

    // Flags come only from the registered occupancy.
    assign count        = cnt;
    assign full         = (cnt == CW'(BUFF_SIZE));
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= CW'(AFULL_LVL));
    assign almost_empty = (cnt <= CW'(AEMPTY_LVL));

    // A pop frees a slot in the same cycle, so push at full is fine with pop.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Storage write; contents survive reset, requests ignored in reset.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wp] <= data_in;
        end
    end

    // Pointers, occupancy and error pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp        <= '0;
            rp        <= '0;
            cnt       <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wp <= (wp == AW'(BUFF_SIZE - 1)) ? '0 : wp + AW'(1);
            end
            if (pop_ok) begin
                rp <= (rp == AW'(BUFF_SIZE - 1)) ? '0 : rp + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
            overflow  <= push & ~push_ok;
            underflow <= pop & ~pop_ok;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head of queue shown directly; zero when nothing is stored.
            always_comb begin
                data_out  = '0;
                out_valid = 1'b0;
                if (!empty) begin
                    data_out  = mem[rp];
                    out_valid = 1'b1;
                end
            end
        end else begin : g_std
            dtype dout_q;
            logic vld_q;

            // Registered read: capture head on accepted pop, hold otherwise.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    dout_q <= '0;
                    vld_q  <= 1'b0;
                end else begin
                    if (pop_ok) begin
                        dout_q <= mem[rp];
                    end
                    vld_q <= pop_ok;
                end
            end

            assign data_out  = dout_q;
            assign out_valid = vld_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed self-checking bench for sync_fifo_flags in both
// standard and first-word-fall-through read modes.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;

    logic       s_push, s_pop;
    logic [7:0] s_din, s_dout;
    logic       s_vld;
    logic [3:0] s_cnt;
    logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;

    logic       f_push, f_pop;
    logic [7:0] f_din, f_dout;
    logic       f_vld;
    logic [3:0] f_cnt;
    logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    int total;
    int bad;

    sync_fifo_flags #(
        .dtype(logic [7:0]), .BUFF_SIZE(8), .FWFT(1'b0),
        .AFULL_LVL(6), .AEMPTY_LVL(1)
    ) u_std (
        .clk(clk), .rst(rst), .push(s_push), .pop(s_pop),
        .data_in(s_din), .data_out(s_dout), .out_valid(s_vld),
        .count(s_cnt), .full(s_full), .empty(s_empty),
        .almost_full(s_af), .almost_empty(s_ae),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_flags #(
        .dtype(logic [7:0]), .BUFF_SIZE(8), .FWFT(1'b1),
        .AFULL_LVL(6), .AEMPTY_LVL(1)
    ) u_ff (
        .clk(clk), .rst(rst), .push(f_push), .pop(f_pop),
        .data_in(f_din), .data_out(f_dout), .out_valid(f_vld),
        .count(f_cnt), .full(f_full), .empty(f_empty),
        .almost_full(f_af), .almost_empty(f_ae),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle on the standard instance; checks run at edge + 1.
    task automatic s_cyc(input logic p, input logic q, input logic [7:0] d);
        s_push = p;
        s_pop  = q;
        s_din  = d;
        @(posedge clk);
        #1;
        s_push = 1'b0;
        s_pop  = 1'b0;
    endtask

    task automatic f_cyc(input logic p, input logic q, input logic [7:0] d);
        f_push = p;
        f_pop  = q;
        f_din  = d;
        @(posedge clk);
        #1;
        f_push = 1'b0;
        f_pop  = 1'b0;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        s_push = 1'b0; s_pop = 1'b0; s_din = 8'h00;
        f_push = 1'b0; f_pop = 1'b0; f_din = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt", 32'(s_cnt), 0);
        chk("rst_empty", 32'(s_empty), 1);
        chk("rst_full", 32'(s_full), 0);
        chk("rst_af", 32'(s_af), 0);
        chk("rst_ae", 32'(s_ae), 1);
        chk("rst_vld", 32'(s_vld), 0);
        chk("rst_ff_dout", 32'(f_dout), 0);
        chk("rst_ff_vld", 32'(f_vld), 0);
        #2 rst = 1'b1;

        // Reset asserted mid-operation
        s_cyc(1, 0, 8'h31);
        s_cyc(1, 0, 8'h32);
        s_cyc(1, 0, 8'h33);
        chk("pre_rst_cnt", 32'(s_cnt), 3);
        s_cyc(0, 1, 8'h00);
        chk("pre_rst_dout", 32'(s_dout), 32'h31);
        chk("pre_rst_vld", 32'(s_vld), 1);
        #1 rst = 1'b0;
        #1;
        chk("arst_cnt", 32'(s_cnt), 0);
        chk("arst_empty", 32'(s_empty), 1);
        chk("arst_ae", 32'(s_ae), 1);
        chk("arst_dout", 32'(s_dout), 0);
        chk("arst_vld", 32'(s_vld), 0);
        #1 rst = 1'b1;
        s_cyc(1, 0, 8'h11);
        chk("post_rst_cnt", 32'(s_cnt), 1);
        s_cyc(0, 1, 8'h00);
        chk("post_rst_dout", 32'(s_dout), 32'h11);
        chk("post_rst_vld", 32'(s_vld), 1);
        s_cyc(0, 0, 8'h00);
        chk("vld_drop", 32'(s_vld), 0);

        // Fill and overflow
        for (int k = 1; k <= 8; k++) begin
            s_cyc(1, 0, 8'(k));
            chk("fill_cnt", 32'(s_cnt), 32'(k));
            chk("fill_af", 32'(s_af), (k >= 6) ? 1 : 0);
            chk("fill_full", 32'(s_full), (k == 8) ? 1 : 0);
            chk("fill_ae", 32'(s_ae), (k <= 1) ? 1 : 0);
        end
        s_cyc(1, 0, 8'h09);
        chk("ovf_pulse", 32'(s_ovf), 1);
        chk("ovf_cnt", 32'(s_cnt), 8);
        s_cyc(0, 0, 8'h00);
        chk("ovf_clear", 32'(s_ovf), 0);

        // Drain and underflow
        for (int k = 1; k <= 8; k++) begin
            s_cyc(0, 1, 8'h00);
            chk("drain_dout", 32'(s_dout), 32'(k));
            chk("drain_vld", 32'(s_vld), 1);
            chk("drain_ae", 32'(s_ae), ((8 - k) <= 1) ? 1 : 0);
            chk("drain_unf", 32'(s_unf), 0);
        end
        s_cyc(0, 1, 8'h00);
        chk("unf_pulse", 32'(s_unf), 1);
        chk("unf_dout", 32'(s_dout), 32'h08);
        chk("unf_empty", 32'(s_empty), 1);
        chk("unf_vld", 32'(s_vld), 0);
        s_cyc(0, 0, 8'h00);
        chk("unf_clear", 32'(s_unf), 0);

        // Wrap-around
        for (int k = 0; k < 5; k++) begin
            s_cyc(1, 0, 8'(8'h10 + k));
            s_cyc(0, 1, 8'h00);
            chk("pp_dout", 32'(s_dout), 32'(8'h10 + k));
        end
        for (int k = 0; k < 8; k++) begin
            s_cyc(1, 0, 8'(8'h20 + k));
        end
        chk("wrap_full", 32'(s_full), 1);
        for (int k = 0; k < 8; k++) begin
            s_cyc(0, 1, 8'h00);
            chk("wrap_dout", 32'(s_dout), 32'(8'h20 + k));
        end
        chk("wrap_empty", 32'(s_empty), 1);

        // Simultaneous push and pop at full
        for (int k = 0; k < 8; k++) begin
            s_cyc(1, 0, 8'(8'h30 + k));
        end
        for (int k = 0; k < 4; k++) begin
            s_cyc(1, 1, 8'(8'h40 + k));
            chk("pp_full_dout", 32'(s_dout), 32'(8'h30 + k));
            chk("pp_full_cnt", 32'(s_cnt), 8);
            chk("pp_full_ovf", 32'(s_ovf), 0);
        end
        for (int k = 0; k < 8; k++) begin
            s_cyc(0, 1, 8'h00);
            chk("pp_drain", 32'(s_dout),
                (k < 4) ? 32'(8'h34 + k) : 32'(8'h40 + k - 4));
        end

        // Simultaneous push and pop at empty
        s_cyc(1, 1, 8'hAA);
        chk("pe_unf", 32'(s_unf), 1);
        chk("pe_cnt", 32'(s_cnt), 1);
        chk("pe_vld", 32'(s_vld), 0);
        s_cyc(0, 1, 8'h00);
        chk("pe_dout", 32'(s_dout), 32'hAA);
        chk("pe_empty", 32'(s_empty), 1);

        // Fall-through mode
        f_cyc(1, 0, 8'hA5);
        chk("ff_dout1", 32'(f_dout), 32'hA5);
        chk("ff_vld1", 32'(f_vld), 1);
        f_cyc(1, 0, 8'h5A);
        chk("ff_hold", 32'(f_dout), 32'hA5);
        chk("ff_cnt2", 32'(f_cnt), 2);
        f_cyc(0, 1, 8'h00);
        chk("ff_dout2", 32'(f_dout), 32'h5A);
        chk("ff_vld2", 32'(f_vld), 1);
        f_cyc(0, 1, 8'h00);
        chk("ff_empty", 32'(f_empty), 1);
        chk("ff_dout0", 32'(f_dout), 0);
        chk("ff_vld0", 32'(f_vld), 0);
        f_cyc(0, 1, 8'h00);
        chk("ff_unf", 32'(f_unf), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

- Parametrised synchronous FIFO; successor to the basic push/pop FIFO.
- Adds over the basic FIFO:
  - Generic element type and depth.
  - Selectable standard or first-word-fall-through (FWFT) read mode.
  - Occupancy count, full/empty and programmable almost-full/almost-empty flags.
  - Overflow/underflow error pulses.
- Buffers records between a producer and a consumer in one clock domain.

## Interface
- `dtype`, `logic [7:0]`: element type; any packed type, e.g. a packed struct record.
- `BUFF_SIZE`, 8: number of entries, ≥ 2, need not be a power of two.
- `FWFT`, 0: 0 = standard registered read, 1 = first-word-fall-through.
- `AFULL_LVL`, `BUFF_SIZE-2`: `almost_full` threshold, 1..BUFF_SIZE.
- `AEMPTY_LVL`, 1: `almost_empty` threshold, 0..BUFF_SIZE-1.
- Out-of-range parameters are an elaboration error.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `push`  in  1  write request.
- `pop`  in  1  read request.
- `data_in`  in  $bits(dtype)  write data.
- `data_out`  out  $bits(dtype)  read data.
- `out_valid`  out  1  `data_out` holds a valid element.
- `count`  out  $clog2(BUFF_SIZE+1)  occupancy.
- `full`, `empty`, `almost_full`, `almost_empty`  out  1  status flags.
- `overflow`, `underflow`  out  1  one-cycle error pulses.

## Operation
- Storage: BUFF_SIZE-entry array, write pointer `wp`, read pointer `rp`.
  - Each pointer wraps from BUFF_SIZE-1 to 0.
  - Storage is not cleared by reset.
- Acceptance, evaluated on the current state:
  - `pop_ok = pop & !empty`.
  - `push_ok = push & (!full | pop_ok)`.
- `push_ok`: write `data_in` at `wp`; `wp` advances.
- `pop_ok`: `rp` advances.
- `count` update:
  - +1 on push_ok only.
  - −1 on pop_ok only.
  - Unchanged when both or neither.
- Simultaneous push and pop:
  - When full: both accepted; count stays BUFF_SIZE.
  - When empty: push accepted, pop rejected (underflow); count becomes 1.
- Flags are decoded combinationally from registered `count`:
  - `full = (count == BUFF_SIZE)`.
  - `empty = (count == 0)`.
  - `almost_full = (count >= AFULL_LVL)`.
  - `almost_empty = (count <= AEMPTY_LVL)`.
- `overflow` is registered high for one cycle after an edge with `push & !push_ok`.
- `underflow` is registered high for one cycle after an edge with `pop & !pop_ok`.
- FWFT=0 (standard mode):
  - On pop_ok, `data_out` is registered with `mem[rp]`.
  - Otherwise `data_out` holds its last value.
  - `out_valid` is registered high for exactly one cycle after a pop_ok edge.
- FWFT=1 (fall-through mode):
  - `data_out = mem[rp]` when !empty, else all-zero.
  - `out_valid = !empty`.
  - pop acknowledges the head currently shown.
- Reset (`rst` low), asynchronous, takes effect immediately, including mid-transfer:
  - `wp = rp = count = 0`.
  - `empty = almost_empty = 1`; `full = almost_full = 0`.
  - `data_out = 0`, `out_valid = 0`, `overflow = underflow = 0`.
- Requests are ignored while `rst` is low. Operation resumes on the first rising edge after release.

## Timing
- Write latency: data pushed at edge N is poppable from edge N+1.
- FWFT=1: it appears on `data_out` after edge N when the FIFO was empty.
- Read latency, FWFT=0: pop sampled at edge N, data valid after edge N (0-cycle from the request edge); held until the next pop_ok.
- Flags and `count` change only after a rising edge (or on reset assertion); no combinational path from `push`/`pop` to any output.
- Throughput: one push and one pop per cycle, sustained, at any occupancy; no bubble at full.
- Error pulses are asserted in the cycle following the offending edge and last exactly one cycle.

## Test plan
Defaults unless stated: dtype 8-bit, BUFF_SIZE=8, AFULL_LVL=6, AEMPTY_LVL=1.
- Reset:
  - Stimulus: push 3 entries, then drop `rst` between edges.
  - Response: immediately count=0, empty=1, almost_empty=1, data_out=0, out_valid=0.
  - After release: a push of 0x11 then a pop returns 0x11.
- Fill and overflow:
  - Stimulus: push 0x01..0x08, then push 0x09.
  - Response: almost_full rises after the 6th edge, full and count=8 after the 8th.
  - The 9th push gives a one-cycle overflow pulse; count stays 8; 0x09 is never read.
- Drain and underflow (FWFT=0):
  - Stimulus: 8 pops, then a 9th pop.
  - Response: data_out 0x01..0x08 in order, out_valid pulsed per pop, almost_empty once count≤1.
  - The 9th pop gives an underflow pulse; data_out holds 0x08; empty=1.
- Wrap-around:
  - Stimulus: push/pop 5 entries (0x10..0x14), then push 0x20..0x27 and pop all.
  - Response: output order is exactly 0x20..0x27 across the pointer wrap.
- Simultaneous push and pop:
  - At full: push+pop for 4 cycles; count stays 8, no overflow, outputs in FIFO order.
  - At empty: push 0xAA with pop; underflow pulse, count=1, next pop returns 0xAA.
- FWFT=1:
  - Stimulus: push 0xA5 into an empty FIFO, then push 0x5A.
  - Response: after the first edge data_out=0xA5, out_valid=1 with no pop.
  - A pop then shows 0x5A.
  - A further pop makes empty=1, data_out=0, out_valid=0.
